// File: rtl/compactador_imediato_pkg.sv
// Shared definitions for the immediate-field narrowing block: format codes,
// field widths and the default overflow-counter width.
package compactador_imediato_pkg;

    localparam logic [1:0] FMT_20   = 2'b00;
    localparam logic [1:0] FMT_14   = 2'b01;
    localparam logic [1:0] FMT_15   = 2'b10;
    localparam logic [1:0] FMT_AUTO = 2'b11;

    localparam int LARG_20 = 20;
    localparam int LARG_14 = 14;
    localparam int LARG_15 = 15;

    localparam int LARG_CONT_PADRAO = 8;

endpackage

// File: rtl/compactador_imediato_verificador_faixa.sv
// Range checker: reports whether a 32-bit signed value is representable in
// a LARGURA-bit two's-complement field. The value fits exactly when
// sign-extending its low LARGURA bits gives the original value back.
module verificador_faixa #(
    parameter int LARGURA = 20
) (
    input  logic signed [31:0] entrada,
    output logic               cabe
);

    logic [31:0] w_estendido;

    assign w_estendido = {{(32-LARGURA){entrada[LARGURA-1]}}, entrada[LARGURA-1:0]};
    assign cabe        = (entrada == w_estendido);

endmodule

// File: rtl/compactador_imediato.sv
// Two-stage valid/ready pipeline that narrows 32-bit signed values into the
// 20/14/15-bit immediate fields, either checking a fixed format or picking
// the narrowest fitting one, with a saturating count of overflowing results.
module compactador_imediato
    import compactador_imediato_pkg::*;
#(
    parameter int LARG_CONT = LARG_CONT_PADRAO
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic signed [31:0]   entrada,
    input  logic [1:0]           selecao,
    input  logic                 entrada_valida,
    output logic                 entrada_pronta,
    output logic [19:0]          saida,
    output logic [1:0]           saida_selecao,
    output logic                 estouro,
    output logic                 saida_valida,
    input  logic                 saida_pronta,
    input  logic                 limpa_contador,
    output logic [LARG_CONT-1:0] contador_estouro
);

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [LARG_CONT-1:0] sat_inc(input logic [LARG_CONT-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    logic                 w_cabe20;
    logic                 w_cabe14;
    logic                 w_cabe15;
    logic                 w_s1_carrega;
    logic                 w_s2_carrega;
    logic                 w_aceita;
    logic                 w_transfere;
    logic [1:0]           w_sel;
    logic                 w_est;
    logic [19:0]          w_saida;

    logic                 r_vld_p1;
    logic [19:0]          r_campo_p1;
    logic [1:0]           r_sel_p1;
    logic                 r_cabe20_p1;
    logic                 r_cabe14_p1;
    logic                 r_cabe15_p1;

    logic                 r_vld_p2;
    logic [19:0]          r_saida_p2;
    logic [1:0]           r_sel_p2;
    logic                 r_est_p2;

    logic [LARG_CONT-1:0] r_cont;

    verificador_faixa #(.LARGURA(LARG_20)) u_faixa20 (.entrada(entrada), .cabe(w_cabe20));
    verificador_faixa #(.LARGURA(LARG_14)) u_faixa14 (.entrada(entrada), .cabe(w_cabe14));
    verificador_faixa #(.LARGURA(LARG_15)) u_faixa15 (.entrada(entrada), .cabe(w_cabe15));

    assign w_s2_carrega   = !r_vld_p2 || saida_pronta;
    assign w_s1_carrega   = !r_vld_p1 || w_s2_carrega;
    assign entrada_pronta = w_s1_carrega;
    assign w_aceita       = entrada_valida && w_s1_carrega;
    assign w_transfere    = r_vld_p2 && saida_pronta;

    // ---- stage 1: capture the low field bits, requested format and fit flags
    // Stage 1 valid flag: refilled whenever the stage is free to load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_carrega) begin
            r_vld_p1 <= entrada_valida;
        end
    end

    // Stage 1 data: only the bits the output can use; the rest live in the flags.
    always_ff @(posedge clock) begin
        if (w_aceita) begin
            r_campo_p1  <= entrada[19:0];
            r_sel_p1    <= selecao;
            r_cabe20_p1 <= w_cabe20;
            r_cabe14_p1 <= w_cabe14;
            r_cabe15_p1 <= w_cabe15;
        end
    end

    // Format resolution and field extraction from the stage-1 contents.
    always_comb begin
        w_sel   = r_sel_p1;
        w_est   = 1'b0;
        w_saida = 20'd0;
        case (r_sel_p1)
            FMT_20: w_est = !r_cabe20_p1;
            FMT_14: w_est = !r_cabe14_p1;
            FMT_15: w_est = !r_cabe15_p1;
            FMT_AUTO: begin
                if (r_cabe14_p1) begin
                    w_sel = FMT_14;
                end else if (r_cabe15_p1) begin
                    w_sel = FMT_15;
                end else begin
                    w_sel = FMT_20;
                    w_est = !r_cabe20_p1;
                end
            end
            default: w_est = 1'b0;
        endcase
        case (w_sel)
            FMT_14:  w_saida = {6'd0, r_campo_p1[13:0]};
            FMT_15:  w_saida = {5'd0, r_campo_p1[14:0]};
            default: w_saida = r_campo_p1;
        endcase
    end

    // ---- stage 2: output register, held while the consumer stalls
    // Stage 2 valid flag and result, loaded when empty or transferring.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p2   <= 1'b0;
            r_saida_p2 <= 20'd0;
            r_sel_p2   <= 2'b00;
            r_est_p2   <= 1'b0;
        end else if (w_s2_carrega) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_saida_p2 <= w_saida;
                r_sel_p2   <= w_sel;
                r_est_p2   <= w_est;
            end
        end
    end

    // Overflow counter: clear wins, otherwise count overflowing transfers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cont <= '0;
        end else if (limpa_contador) begin
            r_cont <= '0;
        end else if (w_transfere && r_est_p2) begin
            r_cont <= sat_inc(r_cont);
        end
    end

    assign saida            = r_saida_p2;
    assign saida_selecao    = r_sel_p2;
    assign estouro          = r_est_p2;
    assign saida_valida     = r_vld_p2;
    assign contador_estouro = r_cont;

endmodule

// File: tb/tb_compactador_imediato.sv
// Directed self-checking bench for compactador_imediato.
module tb_compactador_imediato;

    logic               clock;
    logic               reset_n;
    logic signed [31:0] entrada;
    logic [1:0]         selecao;
    logic               entrada_valida;
    logic               entrada_pronta;
    logic [19:0]        saida;
    logic [1:0]         saida_selecao;
    logic               estouro;
    logic               saida_valida;
    logic               saida_pronta;
    logic               limpa_contador;
    logic [7:0]         contador_estouro;

    int checks = 0;
    int errors = 0;

    compactador_imediato #(.LARG_CONT(8)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .entrada          (entrada),
        .selecao          (selecao),
        .entrada_valida   (entrada_valida),
        .entrada_pronta   (entrada_pronta),
        .saida            (saida),
        .saida_selecao    (saida_selecao),
        .estouro          (estouro),
        .saida_valida     (saida_valida),
        .saida_pronta     (saida_pronta),
        .limpa_contador   (limpa_contador),
        .contador_estouro (contador_estouro)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [19:0] f, input logic [1:0] s);
        case (s)
            2'b01:   return {{18{f[13]}}, f[13:0]};
            2'b10:   return {{17{f[14]}}, f[14:0]};
            default: return {{12{f[19]}}, f};
        endcase
    endfunction

    // One request with the consumer ready; checks latency and the result.
    task automatic envia(input string tag, input logic [31:0] v, input logic [1:0] s,
                         input logic [19:0] exp_saida, input logic [1:0] exp_sel,
                         input logic exp_est);
        entrada        = v;
        selecao        = s;
        entrada_valida = 1'b1;
        saida_pronta   = 1'b1;
        tick();
        entrada_valida = 1'b0;
        chk({tag, ".vld1"}, {31'd0, saida_valida}, 32'd0);
        tick();
        chk({tag, ".vld2"}, {31'd0, saida_valida}, 32'd1);
        chk({tag, ".saida"}, {12'd0, saida}, {12'd0, exp_saida});
        chk({tag, ".sel"}, {30'd0, saida_selecao}, {30'd0, exp_sel});
        chk({tag, ".est"}, {31'd0, estouro}, {31'd0, exp_est});
        if (!exp_est) begin
            chk({tag, ".sext"}, sext(saida, saida_selecao), v);
        end
    endtask

    logic [31:0] vals [6];
    logic [19:0] visto;
    int          in_idx;
    int          out_idx;
    int          ciclo;
    logic        acc;
    logic        xfer;

    initial begin
        reset_n        = 1'b0;
        entrada        = '0;
        selecao        = 2'b00;
        entrada_valida = 1'b0;
        saida_pronta   = 1'b1;
        limpa_contador = 1'b0;
        #12;
        chk("rst.vld", {31'd0, saida_valida}, 32'd0);
        chk("rst.pronta", {31'd0, entrada_pronta}, 32'd1);
        chk("rst.saida", {12'd0, saida}, 32'd0);
        chk("rst.sel", {30'd0, saida_selecao}, 32'd0);
        chk("rst.est", {31'd0, estouro}, 32'd0);
        chk("rst.cont", {24'd0, contador_estouro}, 32'd0);
        #5;
        reset_n = 1'b1;
        tick();

        // Fixed 20-bit format
        envia("f00a", 32'h0007FFFF, 2'b00, 20'h7FFFF, 2'b00, 1'b0);
        envia("f00b", 32'hFFF80000, 2'b00, 20'h80000, 2'b00, 1'b0);
        envia("f00c", 32'h00080000, 2'b00, 20'h80000, 2'b00, 1'b1);
        tick();
        chk("f00c.cont", {24'd0, contador_estouro}, 32'd1);

        // Fixed 14- and 15-bit formats
        envia("f01a", 32'hFFFFE000, 2'b01, 20'h02000, 2'b01, 1'b0);
        envia("f01b", 32'hFFFFDFFF, 2'b01, 20'h01FFF, 2'b01, 1'b1);
        envia("f10a", 32'h00003FFF, 2'b10, 20'h03FFF, 2'b10, 1'b0);

        // Automatic selection
        envia("autoa", 32'h00001FFF, 2'b11, 20'h01FFF, 2'b01, 1'b0);
        envia("autob", 32'h00003FFF, 2'b11, 20'h03FFF, 2'b10, 1'b0);
        envia("autoc", 32'hFFFF8000, 2'b11, 20'hF8000, 2'b00, 1'b0);
        envia("autod", 32'h00100000, 2'b11, 20'h00000, 2'b00, 1'b1);
        envia("autoe", 32'hFFFFF000, 2'b11, 20'h03000, 2'b01, 1'b0);
        tick();
        chk("auto.cont", {24'd0, contador_estouro}, 32'd3);

        // Backpressure: 6 requests, consumer stalled for the first 4 cycles
        for (int k = 0; k < 6; k++) begin
            vals[k] = 32'h00000101 * (k + 1);
        end
        in_idx  = 0;
        out_idx = 0;
        selecao = 2'b00;
        for (ciclo = 0; ciclo < 40 && out_idx < 6; ciclo++) begin
            saida_pronta   = (ciclo >= 4);
            entrada_valida = (in_idx < 6);
            entrada        = (in_idx < 6) ? vals[in_idx] : 32'd0;
            #0;
            if (ciclo == 2 || ciclo == 3) begin
                chk("bp.pronta_baixa", {31'd0, entrada_pronta}, 32'd0);
                chk("bp.estavel", {12'd0, saida}, {12'd0, vals[0][19:0]});
            end
            if (ciclo == 2) visto = saida;
            if (ciclo == 3) chk("bp.hold", {12'd0, saida}, {12'd0, visto});
            acc  = entrada_valida && entrada_pronta;
            xfer = saida_valida && saida_pronta;
            if (xfer) begin
                chk("bp.ordem", {12'd0, saida}, {12'd0, vals[out_idx][19:0]});
                out_idx++;
            end
            tick();
            if (acc) in_idx++;
        end
        entrada_valida = 1'b0;
        saida_pronta   = 1'b1;
        chk("bp.total", out_idx, 32'd6);
        tick();
        chk("bp.vazio", {31'd0, saida_valida}, 32'd0);

        // Saturation: clear, then 300 overflowing transfers
        limpa_contador = 1'b1;
        tick();
        limpa_contador = 1'b0;
        chk("cont.limpo", {24'd0, contador_estouro}, 32'd0);
        entrada        = 32'h00080000;
        selecao        = 2'b00;
        entrada_valida = 1'b1;
        for (int k = 0; k < 300; k++) tick();
        entrada_valida = 1'b0;
        tick();
        tick();
        tick();
        chk("cont.sat", {24'd0, contador_estouro}, 32'd255);

        // Clear coinciding with an overflowing transfer
        limpa_contador = 1'b1;
        tick();
        limpa_contador = 1'b0;
        chk("cont.limpo2", {24'd0, contador_estouro}, 32'd0);
        entrada_valida = 1'b1;
        tick();
        entrada_valida = 1'b0;
        tick();
        chk("cont.pre_vld", {31'd0, saida_valida & estouro}, 32'd1);
        limpa_contador = 1'b1;
        tick();
        limpa_contador = 1'b0;
        chk("cont.prioridade", {24'd0, contador_estouro}, 32'd0);
        envia("cont.inc", 32'h00080000, 2'b00, 20'h80000, 2'b00, 1'b1);
        tick();
        chk("cont.inc1", {24'd0, contador_estouro}, 32'd1);

        // Asynchronous reset with both stages full
        saida_pronta   = 1'b0;
        entrada        = 32'h00000055;
        entrada_valida = 1'b1;
        tick();
        tick();
        entrada_valida = 1'b0;
        chk("rm.cheio", {31'd0, saida_valida}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rm.vld", {31'd0, saida_valida}, 32'd0);
        chk("rm.cont", {24'd0, contador_estouro}, 32'd0);
        chk("rm.pronta", {31'd0, entrada_pronta}, 32'd1);
        #2;
        reset_n      = 1'b1;
        saida_pronta = 1'b1;
        tick();
        chk("rm.descarta", {31'd0, saida_valida}, 32'd0);
        envia("rm.req", 32'h00001FFF, 2'b11, 20'h01FFF, 2'b01, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/compactador_imediato.md
# compactador_imediato

Narrows 32-bit signed values into the processor's immediate fields: 20-bit (format 00), 14-bit (01) and 15-bit (10). For each value it reports whether the value fits the chosen field, or it picks the narrowest field that fits. It sits on the instruction-assembly/patching path, before words are written to instruction memory. It is the inverse of the immediate sign-extension stage: for every non-overflow result, sign-extending `saida` with format `saida_selecao` reproduces `entrada` exactly. It is a 2-stage valid/ready pipeline with a saturating overflow counter.

## Interface
- LARG_CONT, 8, width of the overflow counter
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- entrada  in  32  signed value to narrow
- selecao  in  2  00=20-bit, 01=14-bit, 10=15-bit, 11=auto (narrowest fit)
- entrada_valida  in  1  request valid
- entrada_pronta  out  1  request accepted when high together with entrada_valida
- saida  out  20  narrowed field, right-justified, bits above the field width are zero
- saida_selecao  out  2  format actually used (never 11)
- estouro  out  1  value does not fit the format used
- saida_valida  out  1  result valid
- saida_pronta  in  1  consumer accepts the result when high together with saida_valida
- limpa_contador  in  1  synchronous clear of contador_estouro
- contador_estouro  out  LARG_CONT  saturating count of transferred results with estouro=1

## Operation
- Field width W: 20 for format 00, 14 for 01, 15 for 10. A value fits iff entrada[31:W-1] are all equal (all 0 or all 1).
- Fixed format (00/01/10): saida = entrada[W-1:0] zero-padded to 20 bits; saida_selecao = selecao; estouro = !fits.
- Auto (11): choose 01 if the value fits 14 bits, else 10 if it fits 15, else 00. If it does not fit 20 bits, use 00 with estouro=1 and saida = entrada[19:0].
- Stage 1 registers entrada, selecao and the three fit flags. Stage 2 registers saida, saida_selecao and estouro.
- contador_estouro increments by 1 on each output transfer (saida_valida && saida_pronta) with estouro=1, and holds at 2^LARG_CONT-1.
- limpa_contador has priority: if asserted in the same cycle as a counted transfer, the counter becomes 0.

## Timing
- Latency: a request accepted at edge N gives saida_valida at edge N+2, provided there is no stall.
- Throughput: 1 result per cycle when saida_pronta is held high.
- Stage 2 loads when it is empty or its result is transferring this cycle. Stage 1 loads when it is empty or advancing into stage 2.
- entrada_pronta = !s1_valida || s2 loads this cycle. It is combinational from saida_pronta; there is no combinational path from entrada_valida.
- While saida_valida && !saida_pronta: saida, saida_selecao and estouro are held stable. Up to 2 results can be buffered. No result is dropped or duplicated, and order is preserved.
- Reset (asynchronous, while reset_n=0):
  - both valid flags, saida, saida_selecao, estouro and contador_estouro go to 0;
  - entrada_pronta = 1;
  - in-flight data is discarded.
- Leaving reset: the first request can be accepted at the first rising edge with reset_n=1.

## Structure
- Shared package holds:
  - format codes FMT_20=2'b00, FMT_14=2'b01, FMT_15=2'b10, FMT_AUTO=2'b11;
  - widths 20/14/15;
  - the default LARG_CONT.
- Sub-module `verificador_faixa` (parameter LARGURA, combinational: 32-bit input, outputs `cabe`). It is instantiated 3 times in stage 1.
- Pipeline control, format selection and the counter live in the top module.

## Test plan
- Format 00:
  - 0x0007FFFF -> saida 0x7FFFF, estouro 0.
  - 0xFFF80000 -> saida 0x80000, estouro 0.
  - 0x00080000 -> estouro 1, contador_estouro 1.
- Format 01 and format 10:
  - Format 01, 0xFFFFE000 -> saida 0x02000, estouro 0.
  - Format 01, 0xFFFFDFFF -> estouro 1.
  - Format 10, 0x00003FFF -> saida 0x03FFF, estouro 0.
- Auto:
  - 0x00001FFF -> sel 01, saida 0x01FFF.
  - 0x00003FFF -> sel 10.
  - 0xFFFF8000 -> sel 00, saida 0xF8000.
  - 0x00100000 -> sel 00, estouro 1.
  - Every non-estouro result sign-extends back to entrada.
- Backpressure: stream 6 requests with saida_pronta low for 4 cycles.
  - entrada_pronta falls once both stages are full.
  - saida is stable during the stall.
  - All 6 results come out in order, with none lost or duplicated.
- Counter:
  - 300 overflow transfers -> contador_estouro 255.
  - limpa_contador in the same cycle as an overflow transfer -> 0 on the next cycle.
- Reset mid-stream: with both stages full, drive reset_n low between edges.
  - saida_valida and contador_estouro go to 0 immediately, without waiting for a clock edge.
  - After release, a single request gives its result exactly 2 cycles later.
